// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder.
// Checksum byte support is enabled by defining UART_FRAME_CSUM_EN.
package uart_frame_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;
endpackage

// File: rtl/frame_fifo.sv
// Synchronous first-word-fall-through FIFO. A write into a full FIFO is
// accepted when a read happens in the same cycle.
module frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_empty   = (r_count == CW'(0));
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!o_full || w_rd);
  // Data is forced to zero while empty so the output is defined from reset.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/LEN/payload[/CSUM] byte frames into 32-bit words via a FIFO.
// Define UART_FRAME_CSUM_EN to require and check the trailing CSUM byte.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN    = 64,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic [31:0] word_out,
  output logic        word_out_valid,
  input  logic        word_out_ready,
  output logic        frame_done,
  output logic        frame_error,
  output logic        local_ready,
  output logic [1:0]  dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BYTE_W-1:0] MaxLenB = BYTE_W'(MAX_LEN);

  state_t              r_state;
  logic [BYTE_W-1:0]   r_len;
  logic [BYTE_W-1:0]   r_word_cnt;
  logic [1:0]          r_byte_idx;
  logic [23:0]         r_word_lo;
  logic                r_push;
  logic [WORD_W-1:0]   r_push_data;
  logic                r_ovf;
  logic                r_done;
  logic                r_error;
  logic                r_local_ready;
`ifdef UART_FRAME_CSUM_EN
  logic [BYTE_W-1:0]   r_csum;
  logic                w_csum_bad;
`else
  logic                r_push_last;
`endif

  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic                w_drop;
  logic                w_word_last;

  assign w_pop          = word_out_valid && word_out_ready;
  assign w_drop         = r_push && w_full && !w_pop;
  assign w_word_last    = (r_word_cnt == r_len - 8'd1);
  assign word_out_valid = !w_empty;
  assign frame_done     = r_done;
  assign frame_error    = r_error;
  assign local_ready    = r_local_ready;
  assign dbg_state      = r_state;
`ifdef UART_FRAME_CSUM_EN
  assign w_csum_bad     = (byte_in != r_csum) || r_ovf || w_drop;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= HUNT;
      r_len         <= '0;
      r_word_cnt    <= '0;
      r_byte_idx    <= '0;
      r_word_lo     <= '0;
      r_push        <= 1'b0;
      r_push_data   <= '0;
      r_ovf         <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_local_ready <= 1'b1;
`ifdef UART_FRAME_CSUM_EN
      r_csum        <= '0;
`else
      r_push_last   <= 1'b0;
`endif
    end else begin
      r_push        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_local_ready <= (w_count <= CW'(FIFO_DEPTH - 2));
      if (w_drop) r_ovf <= 1'b1;
`ifndef UART_FRAME_CSUM_EN
      // Without a CSUM byte the frame ends when its last word reaches the FIFO.
      if (r_push && r_push_last) begin
        r_done  <= !(r_ovf || w_drop);
        r_error <= r_ovf || w_drop;
        r_ovf   <= 1'b0;
      end
`endif
      if (byte_in_valid) begin
        case (r_state)
          HUNT: if (byte_in == SYNC_BYTE) r_state <= LEN;
          LEN: begin
            r_len      <= byte_in;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
`ifdef UART_FRAME_CSUM_EN
            r_csum     <= byte_in;
`endif
            if (byte_in == 8'd0) begin
`ifdef UART_FRAME_CSUM_EN
              r_state <= CSUM;
`else
              r_done  <= 1'b1;
              r_state <= HUNT;
`endif
            end else if (byte_in > MaxLenB) begin
              r_error <= 1'b1;
              r_ovf   <= 1'b0;
              r_state <= HUNT;
            end else begin
              r_state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
`ifdef UART_FRAME_CSUM_EN
            r_csum     <= r_csum ^ byte_in;
`endif
            r_byte_idx <= r_byte_idx + 2'd1;
            // Bytes arrive LSB first, so shift in from the top.
            r_word_lo  <= {byte_in, r_word_lo[23:8]};
            if (r_byte_idx == 2'd3) begin
              r_push      <= 1'b1;
              r_push_data <= {byte_in, r_word_lo};
              r_word_cnt  <= r_word_cnt + 8'd1;
`ifdef UART_FRAME_CSUM_EN
              if (w_word_last) r_state <= CSUM;
`else
              r_push_last <= w_word_last;
              if (w_word_last) r_state <= HUNT;
`endif
            end
          end
          CSUM: begin
`ifdef UART_FRAME_CSUM_EN
            r_done  <= !w_csum_bad;
            r_error <= w_csum_bad;
            r_ovf   <= 1'b0;
`endif
            r_state <= HUNT;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  frame_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (r_push),
    .i_wr_data (r_push_data),
    .i_rd_en   (word_out_ready),
    .o_rd_data (word_out),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder; expectations adapt to whether
// UART_FRAME_CSUM_EN is defined for the build.
module tb_uart_frame_decoder;
  localparam logic [1:0] EV_DONE = 2'b01;
  localparam logic [1:0] EV_ERR  = 2'b10;
`ifdef UART_FRAME_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic [31:0] word_out;
  logic        word_out_valid;
  logic        word_out_ready;
  logic        frame_done;
  logic        frame_error;
  logic        local_ready;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [1:0]  ev_q[$];
  int          checks;
  int          failures;

  uart_frame_decoder dut (
    .clock          (clock),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_in_valid  (byte_in_valid),
    .word_out       (word_out),
    .word_out_valid (word_out_valid),
    .word_out_ready (word_out_ready),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .local_ready    (local_ready),
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    byte_in       = b;
    byte_in_valid = 1'b1;
    @(posedge clock); #1;
    byte_in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    repeat (4) @(posedge clock);
    check(name, exp_q.size() + ev_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, word_out_valid, 0);
    check({tag, "_done"},  frame_done, 0);
    check({tag, "_error"}, frame_error, 0);
    check({tag, "_local_ready"}, local_ready, 1);
    check({tag, "_word_out"}, word_out, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word or a pulse
  always @(negedge clock) begin
    if (word_out_valid && word_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word got=%h required=none", word_out);
      end else begin
        check("word_out", word_out, exp_q.pop_front());
      end
    end
    if (frame_done || frame_error) begin
      if (ev_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pulse got=done:%0b,error:%0b required=none", frame_done, frame_error);
      end else begin
        check("frame_pulse", {frame_error, frame_done}, ev_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] seq[$];
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] w;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    byte_in = 8'h00;
    byte_in_valid = 1'b0;
    word_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Two-word frame with matching checksum (0x8A = 02^11^22^...^88)
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    ev_q.push_back(EV_DONE);
    seq = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           (CSUM_ON ? 8'h8A : 8'h02)};
    send_seq(seq);
    wait_idle("drain_good_frame");

    // Same frame with a wrong checksum byte
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    ev_q.push_back(CSUM_ON ? EV_ERR : EV_DONE);
    seq = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h03};
    send_seq(seq);
    wait_idle("drain_bad_csum");

    // Leading garbage then an empty frame
    ev_q.push_back(EV_DONE);
    seq = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    send_seq(seq);
    wait_idle("drain_empty_frame");

    // Oversized LEN, then a normal one-word frame with a latency probe
    ev_q.push_back(EV_ERR);
    send_byte(8'hA5);
    send_byte(8'h41);
    check("len_err_latency", frame_error, 1);
    exp_q.push_back(32'hEFBEADDE);
    ev_q.push_back(EV_DONE);
    seq = {8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE};
    send_seq(seq);
    send_byte(8'hEF);
    check("valid_latency_1", word_out_valid, 0);
    @(posedge clock); #1;
    check("valid_latency_2", word_out_valid, 1);
    if (CSUM_ON) send_byte(8'h23);
    wait_idle("drain_after_len_err");

    // 12-word frame with the consumer stalled: words 9-12 are dropped
    word_out_ready = 1'b0;
    ev_q.push_back(EV_ERR);
    cs = 8'h0C;
    send_byte(8'hA5);
    send_byte(8'h0C);
    for (int n = 0; n < 12; n++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(n * 4 + j + 1);
        w[j*8 +: 8] = b;
        cs = cs ^ b;
        send_byte(b);
      end
      if (n < 8) exp_q.push_back(w);
      if (n == 5) begin
        repeat (2) @(posedge clock); #1;
        check("local_ready_6_stored", local_ready, 1);
      end
      if (n == 6) begin
        repeat (2) @(posedge clock); #1;
        check("local_ready_7_stored", local_ready, 0);
      end
    end
    if (CSUM_ON) send_byte(cs);
    repeat (4) @(posedge clock); #1;
    check("local_ready_full", local_ready, 0);
    word_out_ready = 1'b1;
    wait_idle("drain_overflow");
    #1;
    check("local_ready_drained", local_ready, 1);

    // Reset in the middle of a payload, then a clean frame
    seq = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    send_seq(seq);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("midframe_reset");
    reset = 1'b0;
    repeat (5) @(posedge clock);
    exp_q.push_back(32'h12345678);
    ev_q.push_back(EV_DONE);
    seq = {8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_seq(seq);
    wait_idle("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule
